// File: rtl/ask_frame_sync.sv
// ask_frame_sync: frame synchroniser behind the ASK bit slicer.
// It hunts for an 8-bit sync word in the demodulated bit stream.
// After sync it assembles PAYLOAD_LEN bytes MSB-first and checks a trailing
// XOR checksum byte. It reports each byte, the frame result and a saturating
// bad-frame count.
module ask_frame_sync #(
    parameter logic [7:0] SYNC_WORD   = 8'hA5,
    parameter int         PAYLOAD_LEN = 4,
    parameter int         TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_done,
    output logic       frame_ok,
    output logic       sync_lock,
    output logic [7:0] err_cnt
);

    typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_t;

    localparam logic [3:0]  LEN_LAST = 4'(PAYLOAD_LEN);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYC - 1);

    state_t      state, state_nxt;
    logic [7:0]  sr;          // sync hunt shift register
    logic [3:0]  fill;        // bits seen since entering HUNT, saturates at 8
    logic [7:0]  byte_sr;     // payload byte assembly
    logic [2:0]  bit_cnt;
    logic [3:0]  byte_cnt;
    logic [7:0]  xor_acc;
    logic [15:0] to_cnt;

    logic [7:0]  sr_next;
    logic [7:0]  byte_next;
    logic        sync_hit;
    logic        byte_end;
    logic        chk_end;
    logic        timeout;

    // Error counter increment that sticks at full scale.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Decode of the events that drive both the FSM and the datapath.
    always_comb begin
        sr_next   = {sr[6:0], bit_in};
        byte_next = {byte_sr[6:0], bit_in};
        sync_hit  = (state == HUNT) && bit_valid && (fill >= 4'd7) && (sr_next == SYNC_WORD);
        byte_end  = (state == RECV) && bit_valid && (bit_cnt == 3'd7);
        chk_end   = byte_end && (byte_cnt == LEN_LAST);
        // A strobe in the firing cycle wins: the bit is taken, no timeout.
        timeout   = (state == RECV) && !bit_valid && (to_cnt == TO_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: sync moves to RECV, checksum or silence returns to HUNT.
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = HUNT;
        end else begin
            case (state)
                HUNT:    if (sync_hit) state_nxt = RECV;
                RECV:    if (chk_end || timeout) state_nxt = HUNT;
                default: state_nxt = HUNT;
            endcase
        end
    end

    // Lock indication follows the registered state directly.
    always_comb begin
        sync_lock = (state == RECV);
    end

    // Shift registers, counters and registered frame outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr         <= 8'd0;
            fill       <= 4'd0;
            byte_sr    <= 8'd0;
            bit_cnt    <= 3'd0;
            byte_cnt   <= 4'd0;
            xor_acc    <= 8'd0;
            to_cnt     <= 16'd0;
            data_out   <= 8'd0;
            data_valid <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            err_cnt    <= 8'd0;
        end else begin
            data_valid <= 1'b0;
            frame_done <= 1'b0;
            if (!en) begin
                // Silent abort: results and error count are kept.
                sr       <= 8'd0;
                fill     <= 4'd0;
                byte_sr  <= 8'd0;
                bit_cnt  <= 3'd0;
                byte_cnt <= 4'd0;
                xor_acc  <= 8'd0;
                to_cnt   <= 16'd0;
            end else if (state == HUNT) begin
                to_cnt <= 16'd0;
                if (sync_hit) begin
                    sr       <= 8'd0;
                    fill     <= 4'd0;
                    byte_sr  <= 8'd0;
                    bit_cnt  <= 3'd0;
                    byte_cnt <= 4'd0;
                    xor_acc  <= 8'd0;
                end else if (bit_valid) begin
                    sr <= sr_next;
                    if (fill != 4'd8) fill <= fill + 4'd1;
                end
            end else begin
                if (bit_valid) begin
                    to_cnt  <= 16'd0;
                    byte_sr <= byte_next;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (chk_end) begin
                        frame_done <= 1'b1;
                        frame_ok   <= (byte_next == xor_acc);
                        if (byte_next != xor_acc) err_cnt <= sat_inc8(err_cnt);
                        // Leftover bits must not seed a false sync.
                        sr         <= 8'd0;
                        fill       <= 4'd0;
                    end else if (byte_end) begin
                        data_out   <= byte_next;
                        data_valid <= 1'b1;
                        xor_acc    <= xor_acc ^ byte_next;
                        byte_cnt   <= byte_cnt + 4'd1;
                    end
                end else if (timeout) begin
                    frame_done <= 1'b1;
                    frame_ok   <= 1'b0;
                    err_cnt    <= sat_inc8(err_cnt);
                    sr         <= 8'd0;
                    fill       <= 4'd0;
                    to_cnt     <= 16'd0;
                end else begin
                    to_cnt <= to_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ask_frame_sync.sv
// Directed bench for ask_frame_sync with a short timeout so that whole frames
// and the saturation sequence fit in a modest run.
module tb_ask_frame_sync;

    localparam int TO  = 40;
    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_done;
    logic       frame_ok;
    logic       sync_lock;
    logic [7:0] err_cnt;

    ask_frame_sync #(.SYNC_WORD(8'hA5), .PAYLOAD_LEN(4), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .bit_in(bit_in), .bit_valid(bit_valid),
        .data_out(data_out), .data_valid(data_valid), .frame_done(frame_done),
        .frame_ok(frame_ok), .sync_lock(sync_lock), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [7:0]  chk;
        logic        ok;
    } vec_t;

    vec_t       tbl[7];
    int         errors = 0;
    int         checks = 0;
    int         exp_err = 0;
    int         cyc = 0;
    logic [7:0] dv_q[$];
    int         fd_n = 0;
    logic       last_ok = 1'b0;
    int         fd_cyc = 0;
    int         last_bit_cyc = 0;

    // Observe outputs just after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (data_valid) dv_q.push_back(data_out);
        if (frame_done) begin
            fd_n++;
            last_ok = frame_ok;
            fd_cyc = cyc;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        dv_q.delete();
        fd_n = 0;
    endtask

    // Called at a falling edge; the next bit goes out gap cycles later.
    task automatic send_bit(input logic b, input int gap);
        bit_in = b;
        bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 7; i >= 0; i--) send_bit(b[i], gap);
    endtask

    task automatic bump_err(input logic ok);
        if (!ok && exp_err < 255) exp_err++;
    endtask

    task automatic send_frame(input logic [31:0] d, input logic [7:0] c, input int gap, input logic ck);
        logic [7:0] s;
        s = 8'hA5;
        for (int i = 7; i >= 1; i--) send_bit(s[i], gap);
        if (ck) chk("lock_before_sync", sync_lock, 1'b0);
        send_bit(s[0], gap);
        if (ck) chk("lock_after_sync", sync_lock, 1'b1);
        for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8], gap);
        send_byte(c, gap);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input logic [31:0] d, input logic ok);
        logic [7:0] got;
        chk({tag, "_nbytes"}, dv_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            got = (i < dv_q.size()) ? dv_q[i] : 8'hxx;
            chk({tag, "_byte"}, got, d[(3-i)*8 +: 8]);
        end
        chk({tag, "_frame_done"}, fd_n, 1);
        chk({tag, "_frame_ok"}, last_ok, ok);
        chk({tag, "_err_cnt"}, err_cnt, exp_err);
        chk({tag, "_lock_end"}, sync_lock, 1'b0);
    endtask

    initial begin
        int n;
        tbl[0] = '{32'h12345678, 8'h08, 1'b1};
        tbl[1] = '{32'h12345678, 8'h09, 1'b0};
        tbl[2] = '{32'h00000000, 8'h00, 1'b1};
        tbl[3] = '{32'hFFFFFFFF, 8'h00, 1'b1};
        tbl[4] = '{32'hA5A5A5A5, 8'h00, 1'b1};
        tbl[5] = '{32'h01020408, 8'h0F, 1'b1};
        tbl[6] = '{32'h01020408, 8'hFF, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_data_valid", data_valid, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_frame_ok", frame_ok, 1'b0);
        chk("rst_sync_lock", sync_lock, 1'b0);
        chk("rst_err_cnt", err_cnt, 8'h00);
        rst_n = 1'b1;
        en = 1'b1;
        repeat (2) @(negedge clk);

        // Table of complete frames.
        for (int v = 0; v < 7; v++) begin
            clear_mon();
            send_frame(tbl[v].d, tbl[v].chk, GAP, 1'b1);
            bump_err(tbl[v].ok);
            check_frame($sformatf("vec%0d", v), tbl[v].d, tbl[v].ok);
        end

        // Seven bits of the sync word: no lock, and HUNT never times out.
        clear_mon();
        send_bit(1'b1, GAP); send_bit(1'b0, GAP); send_bit(1'b1, GAP); send_bit(1'b0, GAP);
        send_bit(1'b0, GAP); send_bit(1'b1, GAP); send_bit(1'b0, GAP);
        repeat (3 * TO) @(negedge clk);
        chk("short_lock", sync_lock, 1'b0);
        chk("short_frame_done", fd_n, 0);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);

        // Timeout after one byte and three stray bits.
        clear_mon();
        send_byte(8'hA5, GAP);
        send_byte(8'h12, GAP);
        send_bit(1'b1, GAP);
        send_bit(1'b0, GAP);
        last_bit_cyc = cyc + 1;
        send_bit(1'b1, GAP);
        repeat (2 * TO) @(negedge clk);
        bump_err(1'b0);
        chk("to_nbytes", dv_q.size(), 1);
        chk("to_byte", (dv_q.size() > 0) ? dv_q[0] : 8'hxx, 8'h12);
        chk("to_frame_done", fd_n, 1);
        chk("to_frame_ok", last_ok, 1'b0);
        chk("to_err_cnt", err_cnt, exp_err);
        chk("to_lock", sync_lock, 1'b0);
        chk("to_latency_in_window",
            ((fd_cyc - last_bit_cyc) >= TO - 1) && ((fd_cyc - last_bit_cyc) <= TO + 1), 1'b1);

        // Bits spaced exactly TO cycles: each strobe lands on the firing cycle.
        clear_mon();
        send_frame(32'h12345678, 8'h08, TO, 1'b0);
        check_frame("edge_gap", 32'h12345678, 1'b1);

        // Drop en mid-payload, then a fresh good frame.
        clear_mon();
        send_byte(8'hA5, GAP);
        send_byte(8'h12, GAP);
        send_byte(8'h34, GAP);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        chk("abort_lock", sync_lock, 1'b0);
        chk("abort_data_hold", data_out, 8'h34);
        repeat (2 * TO) @(negedge clk);
        chk("abort_frame_done", fd_n, 0);
        chk("abort_err_hold", err_cnt, exp_err);
        clear_mon();
        send_frame(32'h12345678, 8'h08, GAP, 1'b0);
        check_frame("after_abort", 32'h12345678, 1'b1);

        // Drive the error counter to full scale.
        n = 255 - exp_err;
        for (int i = 0; i < n; i++) begin
            send_frame(32'h12345678, 8'h09, 2, 1'b0);
            bump_err(1'b0);
        end
        chk("sat_reach", err_cnt, 8'd255);
        clear_mon();
        send_frame(32'h12345678, 8'h09, GAP, 1'b0);
        bump_err(1'b0);
        check_frame("sat_bad", 32'h12345678, 1'b0);
        clear_mon();
        send_frame(32'h12345678, 8'h08, GAP, 1'b0);
        check_frame("sat_good", 32'h12345678, 1'b1);

        // Asynchronous reset in the middle of a frame.
        send_byte(8'hA5, GAP);
        send_byte(8'h12, GAP);
        send_bit(1'b1, GAP);
        send_bit(1'b0, GAP);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data_out", data_out, 8'h00);
        chk("arst_data_valid", data_valid, 1'b0);
        chk("arst_frame_done", frame_done, 1'b0);
        chk("arst_frame_ok", frame_ok, 1'b0);
        chk("arst_sync_lock", sync_lock, 1'b0);
        chk("arst_err_cnt", err_cnt, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
